// File: rtl/spi_dac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_dac_pkg
// Brief    : Shared types and helpers for the multi-channel SPI DAC driver.
// Revision : 1.0 - initial release
// ============================================================================
package spi_dac_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PICK  = 3'd1,
        S_SHIFT = 3'd2,
        S_TAIL  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Widest channel mask the lowest-set-bit helper can search.
    localparam int unsigned c_num_ch_max = 32;

    // Width of the channel index for a given channel count (never below 1).
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned lowest_set(input logic [c_num_ch_max-1:0] m);
        int unsigned idx;
        idx = 0;
        for (int i = c_num_ch_max - 1; i >= 0; i--) begin
            if (m[i]) idx = i;
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module   : spi_clk_div
// Brief    : Half-period tick generator; one pulse every div+1 cycles while run.
// Revision : 1.0 - initial release
// ============================================================================
module spi_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             half_tick
);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            r_cnt <= '0;
        end else if (r_cnt == div) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Terminal count is compared, never reached by overflow, so div=all-ones works.
    assign half_tick = run && (r_cnt == div);

endmodule
`default_nettype wire

// File: rtl/spi_dac_multi.sv
`default_nettype none
// ============================================================================
// Module   : spi_dac_multi
// Brief    : Multi-channel 3-wire serial DAC driver, one SPI frame per channel.
// Revision : 1.0 - initial release
// ============================================================================
module spi_dac_multi
    import spi_dac_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8,
    parameter int CPOL   = 1,
    parameter int CS_GAP = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              div_parm,
    input  logic [NUM_CH-1:0]             ch_mask,
    input  logic [NUM_CH*DATA_W-1:0]      ch_data,
    input  logic                          en_conv,
    output logic                          dac_state,
    output logic                          ch_done,
    output logic [ch_idx_w(NUM_CH)-1:0]   ch_idx,
    output logic                          conv_done,
    output logic                          cs_n,
    output logic                          sclk,
    output logic                          din
);

    localparam int   c_idx_w = ch_idx_w(NUM_CH);
    localparam int   c_bit_w = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int   c_gap_w = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic c_idle  = 1'(CPOL);

    state_t                   r_state;
    logic [NUM_CH-1:0]        r_mask;
    logic [NUM_CH*DATA_W-1:0] r_data;
    logic [DIV_W-1:0]         r_div;
    logic [DATA_W-1:0]        r_shift;
    logic [c_idx_w-1:0]       r_cur;
    logic [c_bit_w-1:0]       r_bit_cnt;
    logic [c_gap_w-1:0]       r_gap_cnt;

    logic [c_num_ch_max-1:0]  w_mask_ext;
    logic [NUM_CH-1:0]        w_mask_rest;
    logic [c_idx_w-1:0]       w_pick;
    logic [DATA_W-1:0]        w_word;
    logic                     w_run;
    logic                     w_tick;

    always_comb begin
        w_mask_ext              = '0;
        w_mask_ext[NUM_CH-1:0]  = r_mask;
        w_mask_rest             = r_mask;
        w_mask_rest[r_cur]      = 1'b0;
    end

    assign w_pick = c_idx_w'(lowest_set(w_mask_ext));
    assign w_word = r_data[int'(w_pick)*DATA_W +: DATA_W];
    // Divider idles in PICK so every frame starts with a full half-period.
    assign w_run  = (r_state == S_SHIFT) || (r_state == S_TAIL) || (r_state == S_GAP);

    spi_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .clk       (clk),
        .rst       (rst),
        .run       (w_run),
        .div       (r_div),
        .half_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mask    <= '0;
            r_data    <= '0;
            r_div     <= '0;
            r_shift   <= '0;
            r_cur     <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            dac_state <= 1'b0;
            ch_done   <= 1'b0;
            ch_idx    <= '0;
            conv_done <= 1'b0;
            cs_n      <= 1'b1;
            sclk      <= c_idle;
            din       <= 1'b0;
        end else begin
            ch_done   <= 1'b0;
            conv_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    din <= 1'b0;
                    if (en_conv) begin
                        r_mask    <= ch_mask;
                        r_data    <= ch_data;
                        r_div     <= div_parm;
                        dac_state <= 1'b1;
                        r_state   <= S_PICK;
                    end
                end
                S_PICK: begin
                    if (r_mask == '0) begin
                        conv_done <= 1'b1;
                        dac_state <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cur     <= w_pick;
                        r_shift   <= w_word;
                        din       <= w_word[DATA_W-1];
                        cs_n      <= 1'b0;
                        sclk      <= c_idle;
                        r_bit_cnt <= '0;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        sclk <= ~sclk;
                        // Data only moves on the return to idle, away from the sampling edge.
                        if (sclk != c_idle) begin
                            if (r_bit_cnt == c_bit_w'(DATA_W - 1)) begin
                                r_state <= S_TAIL;
                            end else begin
                                r_shift   <= r_shift << 1;
                                din       <= r_shift[DATA_W-2];
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_TAIL: begin
                    if (w_tick) begin
                        cs_n      <= 1'b1;
                        ch_done   <= 1'b1;
                        ch_idx    <= r_cur;
                        r_mask    <= w_mask_rest;
                        r_gap_cnt <= '0;
                        r_state   <= (w_mask_rest != '0) ? S_GAP : S_DONE;
                    end
                end
                S_GAP: begin
                    if (w_tick) begin
                        if (r_gap_cnt == c_gap_w'(CS_GAP - 1)) begin
                            r_state <= S_PICK;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    conv_done <= 1'b1;
                    dac_state <= 1'b0;
                    din       <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_dac_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_dac_multi
// Brief    : Self-checking bench for spi_dac_multi against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_dac_multi;

    localparam int DATA_W = 16;
    localparam int NUM_CH = 2;
    localparam int DIV_W  = 8;
    localparam int CPOL   = 1;
    localparam int CS_GAP = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [DIV_W-1:0]         div_parm;
    logic [NUM_CH-1:0]        ch_mask;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     en_conv;
    logic                     dac_state;
    logic                     ch_done;
    logic [0:0]               ch_idx;
    logic                     conv_done;
    logic                     cs_n;
    logic                     sclk;
    logic                     din;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    spi_dac_multi #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .DIV_W  (DIV_W),
        .CPOL   (CPOL),
        .CS_GAP (CS_GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .div_parm  (div_parm),
        .ch_mask   (ch_mask),
        .ch_data   (ch_data),
        .en_conv   (en_conv),
        .dac_state (dac_state),
        .ch_done   (ch_done),
        .ch_idx    (ch_idx),
        .conv_done (conv_done),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .din       (din)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: turns pin activity into per-frame records.
    int          fall_q[$];
    int          rise_q[$];
    int          frame_q[$];
    int          bits_q[$];
    int          done_cyc_q[$];
    int          done_idx_q[$];
    int          conv_q[$];
    int          dac_high  = 0;
    int          idle_bad  = 0;
    int          bitcnt    = 0;
    logic [15:0] frame     = '0;
    logic        prev_cs   = 1'b1;
    logic        prev_sclk = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            bitcnt    <= 0;
            frame     <= '0;
            prev_cs   <= 1'b1;
            prev_sclk <= 1'b1;
        end else begin
            if (dac_state) dac_high <= dac_high + 1;
            if (!dac_state && (din !== 1'b0 || cs_n !== 1'b1 || sclk !== 1'b1))
                idle_bad <= idle_bad + 1;
            if (prev_cs && !cs_n) begin
                fall_q.push_back(cyc);
                bitcnt <= 0;
                frame  <= '0;
            end
            if (!cs_n && prev_sclk && !sclk) begin
                frame  <= {frame[14:0], din};
                bitcnt <= bitcnt + 1;
            end
            if (!prev_cs && cs_n) begin
                rise_q.push_back(cyc);
                frame_q.push_back(int'(frame));
                bits_q.push_back(bitcnt);
            end
            if (ch_done) begin
                done_cyc_q.push_back(cyc);
                done_idx_q.push_back(int'(ch_idx));
            end
            if (conv_done) conv_q.push_back(cyc);
            prev_cs   <= cs_n;
            prev_sclk <= sclk;
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // One request: drive it, watch the bus, compare against the frame-level model.
    task automatic run_req(input string tag, input logic [1:0] m, input logic [31:0] d,
                           input logic [7:0] dv, input bit disturb);
        int t0, f0, r0, d0, c0, h0, ib0, k, exp_low, exp_gap, conv_exp, budget, extra;
        int exp_w[$];
        int exp_i[$];
        bit seen;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[i]) begin
                exp_w.push_back(int'(d[i*DATA_W +: DATA_W]));
                exp_i.push_back(i);
            end
        end
        k        = exp_w.size();
        exp_low  = (2 * DATA_W + 1) * (int'(dv) + 1);
        exp_gap  = CS_GAP * (int'(dv) + 1) + 1;
        f0 = fall_q.size(); r0 = rise_q.size(); d0 = done_cyc_q.size();
        c0 = conv_q.size(); h0 = dac_high;      ib0 = idle_bad;

        @(negedge clk);
        ch_mask = m; ch_data = d; div_parm = dv; en_conv = 1'b1;
        t0 = cyc;
        conv_exp = (k == 0) ? t0 + 2 : t0 + 2 + k * exp_low + (k - 1) * exp_gap + 1;
        budget   = conv_exp - t0 + 20;
        @(negedge clk);
        en_conv = 1'b0;
        #1;
        chk({tag, "/busy_rise"}, dac_state, 1);
        seen  = 1'b0;
        extra = 0;
        for (int n = 0; n < budget && extra < 6; n++) begin
            @(negedge clk);
            #1;
            if (disturb && cyc == t0 + 10) begin
                en_conv  = 1'b1;
                ch_data  = $urandom;
                div_parm = 8'($urandom_range(0, 7));
                ch_mask  = 2'b11;
            end else begin
                en_conv = 1'b0;
            end
            if (conv_q.size() > c0) seen = 1'b1;
            if (seen) extra++;
        end
        en_conv = 1'b0;
        chk({tag, "/finished"}, seen, 1);

        chk({tag, "/nframes"}, fall_q.size() - f0, k);
        if (fall_q.size() - f0 == k && rise_q.size() - r0 == k && done_cyc_q.size() - d0 == k) begin
            for (int j = 0; j < k; j++) begin
                chk({tag, "/cs_fall"}, fall_q[f0 + j], t0 + 2 + j * (exp_low + exp_gap));
                chk({tag, "/cs_low"},  rise_q[r0 + j] - fall_q[f0 + j], exp_low);
                chk({tag, "/nbits"},   bits_q[r0 + j], DATA_W);
                chk({tag, "/word"},    frame_q[r0 + j], exp_w[j]);
                chk({tag, "/ch_idx"},  done_idx_q[d0 + j], exp_i[j]);
                chk({tag, "/done_at_rise"}, done_cyc_q[d0 + j], rise_q[r0 + j]);
            end
        end
        chk({tag, "/nconv"}, conv_q.size() - c0, 1);
        if (conv_q.size() - c0 == 1) chk({tag, "/conv_cyc"}, conv_q[c0], conv_exp);
        chk({tag, "/busy_len"}, dac_high - h0, conv_exp - t0 - 1);
        chk({tag, "/idle_pins"}, idle_bad - ib0, 0);
    endtask

    initial begin
        int d0, c0, b;
        bit hit;
        rst = 1'b1; div_parm = '0; ch_mask = '0; ch_data = '0; en_conv = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset/dac_state", dac_state, 0);
        chk("reset/cs_n",      cs_n, 1);
        chk("reset/sclk",      sclk, CPOL);
        chk("reset/din",       din, 0);
        chk("reset/ch_done",   ch_done, 0);
        chk("reset/conv_done", conv_done, 0);
        chk("reset/ch_idx",    ch_idx, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_req("t1", 2'b01, {16'h0000, 16'hCAAA}, 8'd0, 1'b0);
        run_req("t2", 2'b11, {16'h4555, 16'hCAAA}, 8'd0, 1'b0);
        run_req("t3", 2'b10, {16'h8001, 16'($urandom)}, 8'd3, 1'b0);
        run_req("t4", 2'b11, $urandom, 8'd2, 1'b1);

        // Reset in the middle of a frame, then a clean request.
        d0 = done_cyc_q.size(); c0 = conv_q.size();
        @(negedge clk);
        ch_mask = 2'b01; ch_data = $urandom; div_parm = 8'd0; en_conv = 1'b1;
        @(negedge clk);
        en_conv = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 100 && !hit; n++) begin
            @(negedge clk);
            #1;
            if (bitcnt == 7) hit = 1'b1;
        end
        chk("t5/reached_bit7", hit, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("t5/cs_n",      cs_n, 1);
        chk("t5/sclk",      sclk, CPOL);
        chk("t5/din",       din, 0);
        chk("t5/dac_state", dac_state, 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("t5/no_ch_done",   done_cyc_q.size() - d0, 0);
        chk("t5/no_conv_done", conv_q.size() - c0, 0);
        run_req("t5b", 2'b01, $urandom, 8'd1, 1'b0);

        run_req("t6", 2'b00, $urandom, 8'd5, 1'b0);

        for (int i = 0; i < 6; i++) begin
            b = $urandom_range(0, 3);
            run_req($sformatf("rnd%0d", i), 2'(b), $urandom, 8'($urandom_range(0, 6)), 1'(i % 2));
        end

        run_req("maxdiv", 2'b01, $urandom, 8'hFF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
